// File: rtl/program_memory_loadable.sv
// Writable instruction memory with a zero-latency fetch port, a post-reset NOP sweep,
// and a valid/ready byte-stream loader. The CPU is held and fed FILL_VALUE unless running.
module program_memory_loadable #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = DATA_WIDTH'(8'b0111_0000),
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_bus,
    output logic [DATA_WIDTH-1:0] data_bus,
    output logic                  cpu_hold,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_error
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
    logic                  load_error_q, load_error_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        load_error_d = load_error_q;
        mem_we       = 1'b0;
        mem_waddr    = clr_ptr_q;
        mem_wdata    = FILL_VALUE;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = load_base;
                    load_count_d = '0;
                    load_error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // A restart takes priority over any beat presented in the same cycle.
                if (load_start) begin
                    wr_ptr_d     = load_base;
                    load_count_d = '0;
                    load_error_d = 1'b0;
                end else if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q;
                    mem_wdata = load_data;
                    if (load_count_q != COUNT_MAX) begin
                        load_count_d = load_count_q + 1'b1;
                    end
                    if (wr_ptr_q != LAST_ADDR) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Image ran past the top of memory: keep what fit, flag it, resume.
                        load_error_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RESET_STATE;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            load_error_q <= load_error_d;
        end
    end

    // Storage is deliberately outside the reset domain; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign cpu_hold   = (state_q != ST_RUN);
    assign load_ready = (state_q == ST_LOAD);
    assign data_bus   = (state_q == ST_RUN) ? mem_q[address_bus] : FILL_VALUE;
    assign load_count = load_count_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_program_memory_loadable.sv
// Bench for program_memory_loadable: default 8x256 instance with clear sweep, plus a
// 16x16 instance without clear. Expected memory comes from a simple array model.
module tb_program_memory_loadable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst_n;
    logic [7:0]  address_bus, data_bus, load_base, load_data;
    logic        cpu_hold, load_start, load_valid, load_last, load_ready, load_error;
    logic [8:0]  load_count;

    // 16-bit, no-clear instance
    logic        rst16_n;
    logic [3:0]  addr16, base16;
    logic [15:0] data16, ldata16;
    logic        hold16, start16, valid16, last16, ready16, error16;
    logic [4:0]  count16;

    program_memory_loadable u_dut (
        .clk(clk), .reset(rst_n), .address_bus(address_bus), .data_bus(data_bus),
        .cpu_hold(cpu_hold), .load_start(load_start), .load_base(load_base),
        .load_data(load_data), .load_valid(load_valid), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count), .load_error(load_error)
    );

    program_memory_loadable #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0)) u_dut16 (
        .clk(clk), .reset(rst16_n), .address_bus(addr16), .data_bus(data16),
        .cpu_hold(hold16), .load_start(start16), .load_base(base16),
        .load_data(ldata16), .load_valid(valid16), .load_last(last16),
        .load_ready(ready16), .load_count(count16), .load_error(error16)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int         nerr = 0;
    int         nchecks = 0;
    logic [7:0] model [256];
    logic [7:0] wq [$];
    logic [15:0] w16 [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill();
        for (int a = 0; a < 256; a++) model[a] = 8'h70;
    endtask

    task automatic verify_all(input string nm);
        for (int a = 0; a < 256; a++) begin
            address_bus = 8'(a);
            #1;
            chk(nm, data_bus, model[a]);
        end
    endtask

    // Count cycles until the CPU is released; optionally pulse load_start mid-sweep.
    task automatic wait_clear(input int pulse_at);
        int n = 0;
        address_bus = 8'h00;
        while (cpu_hold === 1'b1 && n < 1000) begin
            load_start = (n == pulse_at);
            load_base  = 8'h00;
            if (n == 3) begin
                chk("fill during clear", data_bus, 8'h70);
                chk("ready during clear", load_ready, 1'b0);
            end
            tick();
            n++;
        end
        load_start = 1'b0;
        chk("clear length", n, 256);
    endtask

    // Streams wq starting at base. mode 0: always valid, 1: alternate valid, 2: random gaps.
    task automatic do_load(input logic [7:0] base, input int mode);
        int  n     = wq.size();
        int  avail = 256 - int'(base);
        int  acc   = (n <= avail) ? n : avail;
        bit  oflow = (n > avail);
        int  i     = 0;
        int  cyc   = 0;
        bit  v;
        load_base  = base;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_base  = 8'($urandom);
        chk("ready after start", load_ready, 1'b1);
        chk("count cleared at start", load_count, 9'd0);
        chk("error cleared at start", load_error, 1'b0);
        while (i < acc && cyc < 200) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            load_valid  = v;
            load_data   = v ? wq[i] : 8'hEE;
            load_last   = v ? (i == n - 1) : 1'b1;
            address_bus = 8'($urandom);
            #1;
            chk("hold during load", cpu_hold, 1'b1);
            chk("fill during load", data_bus, 8'h70);
            @(posedge clk);
            #1;
            if (v) i++;
            cyc++;
        end
        chk("load beats within budget", (cyc < 200), 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        for (int k = 0; k < acc; k++) model[8'(int'(base) + k)] = wq[k];
        address_bus = 8'(int'(base) + acc - 1);
        #1;
        chk("hold after load", cpu_hold, 1'b0);
        chk("ready after load", load_ready, 1'b0);
        chk("load_count", load_count, 9'(acc));
        chk("load_error", load_error, 1'(oflow));
        chk("last word fetchable", data_bus, wq[acc-1]);
        if (oflow) begin
            load_valid = 1'b1;
            load_data  = 8'h5A;
            #1;
            chk("no ready after overflow", load_ready, 1'b0);
            tick();
            load_valid = 1'b0;
            chk("error sticky", load_error, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t    vecs [8];
        logic [7:0] prog [19] = '{8'h80, 8'h40, 8'h82, 8'h00, 8'h84, 8'h01, 8'h20, 8'h10,
                                  8'hA0, 8'h11, 8'h40, 8'h12, 8'h50, 8'h01, 8'hC0, 8'h13,
                                  8'hE0, 8'h00, 8'hFF};
        vecs[0] = '{8'h00, 8'h80};
        vecs[1] = '{8'h01, 8'h40};
        vecs[2] = '{8'h02, 8'h82};
        vecs[3] = '{8'h03, 8'h00};
        vecs[4] = '{8'h0A, 8'h40};
        vecs[5] = '{8'h12, 8'hFF};
        vecs[6] = '{8'h13, 8'h70};
        vecs[7] = '{8'hFF, 8'h70};

        rst_n = 1'b0; rst16_n = 1'b0;
        address_bus = '0; load_start = 0; load_base = '0; load_data = '0;
        load_valid = 0; load_last = 0;
        addr16 = '0; start16 = 0; base16 = '0; ldata16 = '0; valid16 = 0; last16 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst16_n = 1'b1;
        #1;
        chk("reset cpu_hold", cpu_hold, 1'b1);
        chk("reset load_ready", load_ready, 1'b0);
        chk("reset data_bus", data_bus, 8'h70);
        chk("reset load_count", load_count, 9'd0);
        chk("reset load_error", load_error, 1'b0);
        chk("no-clear reset cpu_hold", hold16, 1'b0);
        chk("no-clear reset load_ready", ready16, 1'b0);

        wait_clear(-1);
        model_fill();
        verify_all("post-clear mem");

        // Averaging program at base 0, then table-driven fetches
        wq.delete();
        for (int k = 0; k < 19; k++) wq.push_back(prog[k]);
        do_load(8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            address_bus = vecs[k].addr;
            #1;
            chk("program fetch", data_bus, vecs[k].exp);
        end

        // Toggling valid at 0x10
        wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_load(8'h10, 1);
        verify_all("after toggled load");

        // Restart while a beat is presented: the beat must be dropped
        load_base = 8'h30; load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h11; load_last = 1'b0; tick();
        load_data = 8'h22; tick();
        load_start = 1'b1; load_base = 8'h40; load_data = 8'h99; load_last = 1'b1; tick();
        load_start = 1'b0;
        chk("restart stays in load", cpu_hold, 1'b1);
        chk("restart count", load_count, 9'd0);
        load_data = 8'h55; tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("restart final count", load_count, 9'd1);
        model[8'h30] = 8'h11; model[8'h31] = 8'h22; model[8'h40] = 8'h55;
        verify_all("after restart");

        // Overflow at top of memory
        wq = '{8'hB1, 8'hB2, 8'hB3};
        do_load(8'hFE, 0);
        verify_all("after overflow");

        // Randomised loads against the array model
        for (int it = 0; it < 6; it++) begin
            logic [7:0] b;
            int         len;
            b   = (it % 3 == 0) ? 8'(256 - $urandom_range(1, 6)) : 8'($urandom);
            len = $urandom_range(1, 12);
            wq.delete();
            for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
            do_load(b, 2);
        end
        verify_all("after random loads");

        // Reset in the middle of a load
        load_base = 8'h50; load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_data = 8'(8'hC0 + k);
            tick();
        end
        chk("mid-load count", load_count, 9'd5);
        rst_n = 1'b0;
        #1;
        chk("mid-load reset hold", cpu_hold, 1'b1);
        chk("mid-load reset count", load_count, 9'd0);
        chk("mid-load reset error", load_error, 1'b0);
        chk("mid-load reset ready", load_ready, 1'b0);
        tick(); tick();
        load_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        wait_clear(10);
        model_fill();
        verify_all("after reset sweep");

        // 16-bit instance: full 16-word image, last on the 16th
        start16 = 1'b1; base16 = 4'h0; tick(); start16 = 1'b0;
        chk("w16 ready", ready16, 1'b1);
        for (int k = 0; k < 16; k++) begin
            w16[k]  = 16'($urandom);
            valid16 = 1'b1;
            ldata16 = w16[k];
            last16  = (k == 15);
            tick();
            if (k == 7) chk("w16 mid count", count16, 5'd8);
        end
        valid16 = 1'b0; last16 = 1'b0;
        chk("w16 hold", hold16, 1'b0);
        chk("w16 count", count16, 5'd16);
        chk("w16 error", error16, 1'b0);
        for (int k = 0; k < 16; k++) begin
            addr16 = 4'(k);
            #1;
            chk("w16 readback", data16, w16[k]);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
